// File: rtl/run_controller.sv
// Sequencer between the host byte loader and the RISC-V top: packs program bytes into
// instruction-memory words, releases CPU reset, pulses startProcess and times the run.
module run_controller #(
  parameter int unsigned IM_MEM_DEPTH   = 256,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned IM_ADDR_W     = $clog2(IM_MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_byte,
  input  logic                 ld_last,
  output logic                 ld_ready,
  input  logic                 run_req,
  input  logic                 abort,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_rstN,
  output logic                 startProcess,
  input  logic                 endProcess,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 load_err,
  output logic [CNT_W-1:0]     cycle_count
);

  // One extra bit so the word index can reach IM_MEM_DEPTH (memory full).
  localparam int unsigned IDX_W = IM_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READY, S_START, S_RUN, S_DONE, S_TIMEOUT, S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic [1:0]           lane_q, lane_d;
  logic [31:0]          wbuf_q, wbuf_d;
  logic [CNT_W-1:0]     count_d;
  logic                 im_we_d;
  logic [IM_ADDR_W-1:0] im_addr_d;
  logic [31:0]          im_wdata_d;

  logic                 fresh;
  logic                 take;
  logic [IDX_W-1:0]     base_idx;
  logic [1:0]           base_lane;
  logic [31:0]          base_buf;
  logic [31:0]          merged;

  // Next-state, byte packing and run timing.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    lane_d     = lane_q;
    wbuf_d     = wbuf_q;
    count_d    = cycle_count;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr;
    im_wdata_d = im_wdata;
    take       = 1'b0;

    // Any byte accepted outside LOAD starts a new program at word 0, lane 0.
    fresh     = (state_q != S_LOAD);
    base_idx  = fresh ? '0 : word_idx_q;
    base_lane = fresh ? 2'd0 : lane_q;
    base_buf  = fresh ? 32'd0 : wbuf_q;
    merged    = base_buf | (32'(ld_byte) << {base_lane, 3'b000});

    if (abort) begin
      state_d = S_IDLE;
      lane_d  = 2'd0;
      wbuf_d  = 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: take = ld_valid;
        S_READY:        if (run_req) state_d = S_START;
        S_START:        state_d = S_RUN;
        S_RUN: begin
          if (endProcess)
            state_d = S_DONE;
          else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1))
            state_d = S_TIMEOUT;
          else if (cycle_count != '1)
            count_d = cycle_count + CNT_W'(1);
        end
        S_DONE:    if (run_req) state_d = S_START;
                   else take = ld_valid;
        S_TIMEOUT: if (run_req) state_d = S_READY;
                   else take = ld_valid;
        S_FAULT:   state_d = S_FAULT;
      endcase

      if (take) begin
        if (base_idx == IDX_W'(IM_MEM_DEPTH)) begin
          state_d = S_FAULT;
          lane_d  = 2'd0;
          wbuf_d  = 32'd0;
        end else begin
          state_d = ld_last ? S_READY : S_LOAD;
          if (ld_last || (base_lane == 2'd3)) begin
            im_we_d    = 1'b1;
            im_addr_d  = base_idx[IM_ADDR_W-1:0];
            im_wdata_d = merged;
            word_idx_d = base_idx + IDX_W'(1);
            lane_d     = 2'd0;
            wbuf_d     = 32'd0;
          end else begin
            word_idx_d = base_idx;
            lane_d     = base_lane + 2'd1;
            wbuf_d     = merged;
          end
        end
      end
    end

    if (state_d == S_START) count_d = '0;
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_idx_q   <= '0;
      lane_q       <= 2'd0;
      wbuf_q       <= 32'd0;
      cycle_count  <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= 32'd0;
      ld_ready     <= 1'b1;
      cpu_rstN     <= 1'b0;
      startProcess <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      lane_q       <= lane_d;
      wbuf_q       <= wbuf_d;
      cycle_count  <= count_d;
      im_we        <= im_we_d;
      im_addr      <= im_addr_d;
      im_wdata     <= im_wdata_d;
      ld_ready     <= (state_d == S_IDLE) || (state_d == S_LOAD);
      cpu_rstN     <= !((state_d == S_IDLE) || (state_d == S_LOAD) ||
                        (state_d == S_TIMEOUT) || (state_d == S_FAULT));
      startProcess <= (state_d == S_START);
      busy         <= (state_d == S_LOAD) || (state_d == S_START) || (state_d == S_RUN);
      done         <= (state_d == S_DONE);
      timeout      <= (state_d == S_TIMEOUT);
      load_err     <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: random program loads and runs checked against a packing/timing model.
module tb_run_controller;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned CW    = 32;
  localparam int unsigned TMO   = 64;

  logic clk = 1'b0;
  logic rst, ld_valid, ld_last, run_req, abort, endProcess;
  logic [7:0] ld_byte;
  logic ld_ready, im_we, cpu_rstN, startProcess, busy, done, timeout, load_err;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [CW-1:0] cycle_count;

  int total = 0;
  int bad   = 0;
  int sp_cnt = 0;
  logic [7:0] prog[$];
  logic [AW+31:0] wr_log[$];

  always #5 clk = ~clk;

  run_controller #(.IM_MEM_DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .run_req(run_req), .abort(abort), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rstN(cpu_rstN),
    .startProcess(startProcess), .endProcess(endProcess), .busy(busy), .done(done),
    .timeout(timeout), .load_err(load_err), .cycle_count(cycle_count)
  );

  // Record every memory write and every start pulse.
  always @(negedge clk) begin
    if (im_we === 1'b1) wr_log.push_back({im_addr, im_wdata});
    if (startProcess === 1'b1) sp_cnt++;
  end

  task automatic go_idle();
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  // Stream prog[] one byte per cycle, then compare writes against little-endian packing.
  task automatic load_and_check(input string tag);
    int n, nb, nw, base;
    bit fault, broke;
    logic [31:0] word;
    logic [AW+31:0] got;
    n = prog.size();
    fault = (n > int'(4 * DEPTH));
    nb = fault ? int'(4 * DEPTH) : n;
    nw = (nb + 3) / 4;
    base = wr_log.size();
    broke = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ld_ready !== 1'b1) begin broke = 1'b1; break; end
      ld_valid = 1'b1; ld_byte = prog[i]; ld_last = (i == n - 1);
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0;
    end
    if (!broke) @(negedge clk);
    if (fault) begin
      total++;
      if ({load_err, ld_ready, cpu_rstN, im_we} !== 4'b1000) begin
        bad++;
        $display("FAIL %s_fault_entry got %b want 1000", tag, {load_err, ld_ready, cpu_rstN, im_we});
      end
    end else begin
      total++;
      if ({im_we, cpu_rstN, busy, ld_ready, load_err} !== 5'b11000) begin
        bad++;
        $display("FAIL %s_ready_entry got %b want 11000", tag, {im_we, cpu_rstN, busy, ld_ready, load_err});
      end
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (wr_log.size() - base != nw) begin
      bad++;
      $display("FAIL %s_write_count got %0d want %0d", tag, wr_log.size() - base, nw);
    end
    for (int wi = 0; wi < nw; wi++) begin
      word = 32'd0;
      for (int l = 0; l < 4; l++)
        if (wi * 4 + l < nb) word[8*l +: 8] = prog[wi*4 + l];
      got = (base + wi < wr_log.size()) ? wr_log[base + wi] : 'x;
      total++;
      if (got !== {AW'(wi), word}) begin
        bad++;
        $display("FAIL %s_write%0d got %h want %h", tag, wi, got, {AW'(wi), word});
      end
    end
  endtask

  // From READY/DONE/TIMEOUT: start a run, raise endProcess in RUN cycle k (if use_end).
  task automatic run_once(input int k, input bit use_end);
    int sp0, fin_i, exp_i;
    bit exp_done, finished;
    logic [CW-1:0] exp_cnt;
    exp_done = use_end && (k <= int'(TMO));
    exp_cnt  = exp_done ? CW'(k - 1) : CW'(TMO - 1);
    exp_i    = exp_done ? k + 1 : int'(TMO) + 1;
    if (timeout === 1'b1) begin
      @(negedge clk); run_req = 1'b1;
      @(posedge clk); #1; run_req = 1'b0;
      total++;
      if ({cpu_rstN, timeout, busy} !== 3'b100) begin
        bad++;
        $display("FAIL timeout_to_ready got %b want 100", {cpu_rstN, timeout, busy});
      end
    end
    sp0 = sp_cnt;
    @(negedge clk); run_req = 1'b1;
    @(posedge clk); #1; run_req = 1'b0;
    total++;
    if ({startProcess, busy, cpu_rstN, done, timeout} !== 5'b11100 || cycle_count !== '0) begin
      bad++;
      $display("FAIL start_cycle got %b cnt=%0d want 11100 cnt=0",
               {startProcess, busy, cpu_rstN, done, timeout}, cycle_count);
    end
    finished = 1'b0;
    fin_i = 0;
    for (int i = 1; i <= int'(TMO) + 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || timeout === 1'b1) begin finished = 1'b1; fin_i = i; break; end
      endProcess = use_end && (i == k);
    end
    endProcess = 1'b0;
    total++;
    if (!finished || fin_i != exp_i) begin
      bad++;
      $display("FAIL run_end_cycle k=%0d got %0d want %0d", k, fin_i, exp_i);
    end
    total++;
    if ({done, timeout, busy, cpu_rstN} !== {exp_done, !exp_done, 1'b0, exp_done}) begin
      bad++;
      $display("FAIL run_status k=%0d got %b want %b", k, {done, timeout, busy, cpu_rstN},
               {exp_done, !exp_done, 1'b0, exp_done});
    end
    total++;
    if (cycle_count !== exp_cnt) begin
      bad++;
      $display("FAIL run_count k=%0d got %0d want %0d", k, cycle_count, exp_cnt);
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (sp_cnt - sp0 != 1 || cycle_count !== exp_cnt) begin
      bad++;
      $display("FAIL run_pulses_hold k=%0d got pulses=%0d cnt=%0d want pulses=1 cnt=%0d",
               k, sp_cnt - sp0, cycle_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
    run_req = 1'b0; abort = 1'b0; endProcess = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({ld_ready, cpu_rstN, busy, done, timeout, load_err, im_we, startProcess} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_flags got %b want 10000000",
               {ld_ready, cpu_rstN, busy, done, timeout, load_err, im_we, startProcess});
    end
    total++;
    if (cycle_count !== '0 || im_addr !== '0 || im_wdata !== '0) begin
      bad++;
      $display("FAIL reset_regs got cnt=%0d addr=%0d data=%h want 0", cycle_count, im_addr, im_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [7:0] b [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int base;
    base = wr_log.size();
    prog.delete();
    foreach (b[i]) prog.push_back(b[i]);
    load_and_check("basic");
    total++;
    if (wr_log.size() < base + 2 || wr_log[base] !== {2'd0, 32'h0000_0013} ||
        wr_log[base+1] !== {2'd1, 32'h0010_0093}) begin
      bad++;
      $display("FAIL basic_words got %0d writes want 0:00000013 1:00100093", wr_log.size() - base);
    end
  endtask

  task automatic test_runs();
    run_once(51, 1'b1);
    run_once(int'(TMO), 1'b1);
    run_once(0, 1'b0);
    repeat (6) run_once(int'($urandom_range(1, TMO + 10)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_run_req_beats_load();
    int base;
    run_once(5, 1'b1);
    base = wr_log.size();
    @(negedge clk); run_req = 1'b1; ld_valid = 1'b1; ld_byte = 8'hAA; ld_last = 1'b1;
    @(posedge clk); #1; run_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    total++;
    if ({startProcess, busy, ld_ready} !== 3'b110) begin
      bad++;
      $display("FAIL done_collision got %b want 110", {startProcess, busy, ld_ready});
    end
    go_idle();
    repeat (2) @(posedge clk); #1;
    total++;
    if (wr_log.size() != base) begin
      bad++;
      $display("FAIL done_collision_writes got %0d want 0", wr_log.size() - base);
    end
  endtask

  task automatic test_partial_and_random_loads();
    go_idle();
    prog.delete();
    for (int i = 1; i <= 6; i++) prog.push_back(8'(8'h11 * i));
    load_and_check("partial6");
    repeat (5) begin
      go_idle();
      prog.delete();
      repeat ($urandom_range(1, 4 * DEPTH)) prog.push_back(8'($urandom));
      load_and_check("rand_load");
    end
  endtask

  task automatic test_fault();
    for (int r = 0; r < 2; r++) begin
      go_idle();
      prog.delete();
      repeat (r == 0 ? 17 : $urandom_range(18, 22)) prog.push_back(8'($urandom));
      load_and_check("overflow");
      go_idle();
      @(negedge clk);
      total++;
      if ({load_err, ld_ready, busy, cpu_rstN} !== 4'b0100) begin
        bad++;
        $display("FAIL fault_abort got %b want 0100", {load_err, ld_ready, busy, cpu_rstN});
      end
    end
  endtask

  task automatic test_abort_load();
    int base;
    go_idle();
    base = wr_log.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ld_valid = 1'b1; ld_byte = 8'(8'hA0 + i); ld_last = 1'b0;
      @(posedge clk); #1; ld_valid = 1'b0;
    end
    go_idle();
    repeat (2) @(posedge clk); #1;
    total++;
    if (wr_log.size() - base != 1 || {ld_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL abort_load got writes=%0d rdy_busy=%b want 1 10", wr_log.size() - base, {ld_ready, busy});
    end
    prog.delete();
    repeat (3) prog.push_back(8'($urandom));
    load_and_check("after_abort");
  endtask

  task automatic test_abort_run();
    int a;
    for (int r = 0; r < 3; r++) begin
      a = (r == 0) ? 8 : int'($urandom_range(1, TMO));
      go_idle();
      prog.delete();
      repeat (4) prog.push_back(8'($urandom));
      load_and_check("pre_abort_run");
      @(negedge clk); run_req = 1'b1;
      @(posedge clk); #1; run_req = 1'b0;
      for (int i = 1; i <= a; i++) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      total++;
      if ({busy, cpu_rstN, ld_ready, done, timeout} !== 5'b00100 || cycle_count !== CW'(a - 1)) begin
        bad++;
        $display("FAIL abort_run a=%0d got %b cnt=%0d want 00100 cnt=%0d",
                 a, {busy, cpu_rstN, ld_ready, done, timeout}, cycle_count, a - 1);
      end
      repeat (3) @(posedge clk); #1;
      total++;
      if (cycle_count !== CW'(a - 1)) begin
        bad++;
        $display("FAIL abort_hold a=%0d got %0d want %0d", a, cycle_count, a - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_runs();
    test_run_req_beats_load();
    test_partial_and_random_loads();
    test_fault();
    test_abort_load();
    test_abort_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
